// File: rtl/fpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpu_pkg : shared single-precision constants, class bit indices, FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int CLS_W    = 6;
    localparam int CLS_ZERO = 0;
    localparam int CLS_SUB  = 1;
    localparam int CLS_NORM = 2;
    localparam int CLS_INF  = 3;
    localparam int CLS_SNAN = 4;
    localparam int CLS_QNAN = 5;

    localparam logic [7:0]  BIAS       = 8'd127;
    localparam logic [31:0] CANON_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } fdiv_state_e;

endpackage
`default_nettype wire

// File: rtl/fclass.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fclass : one-hot IEEE-754 single-precision operand classifier
// Rev 1.0
// ---------------------------------------------------------------------------
module fclass
    import fpu_pkg::*;
(
    input  logic [31:0]      op,
    output logic [CLS_W-1:0] cls
);

    always_comb begin
        cls = '0;
        if (op[30:23] == 8'h00) begin
            if (op[22:0] == 23'd0) cls[CLS_ZERO] = 1'b1;
            else                   cls[CLS_SUB]  = 1'b1;
        end else if (op[30:23] == 8'hFF) begin
            if (op[22:0] == 23'd0) cls[CLS_INF]  = 1'b1;
            else if (op[22])       cls[CLS_QNAN] = 1'b1;
            else                   cls[CLS_SNAN] = 1'b1;
        end else begin
            cls[CLS_NORM] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fdiv_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fdiv_iter : iterative single-precision divider, restoring, round-to-zero
// Rev 1.0
// ---------------------------------------------------------------------------
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int ITER = 25
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fdivStart_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        fdivBusy_o,
    output logic        fdivDone_o,
    output logic [31:0] fdivOut_o
);

    localparam int                CNT_W       = $clog2(ITER);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(ITER - 1);
    localparam logic signed [9:0] EXP_MAX     = $signed({2'b00, BIAS});
    localparam logic signed [9:0] EXP_MIN     = 10'sd1 - EXP_MAX;
    localparam logic signed [9:0] EXP_SUB_MIN = EXP_MIN - 10'sd23;

    fdiv_state_e state, state_next;

    logic [CLS_W-1:0] cls1, cls2;
    logic             sign_r;
    logic [7:0]       ea_r, eb_r;
    logic [24:0]      rem;
    logic [23:0]      dvs;
    logic [ITER-1:0]  quo;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      out_r;

    fclass u_cls1 (.op(rs1_i), .cls(cls1));
    fclass u_cls2 (.op(rs2_i), .cls(cls2));

    logic        sign_in, zero1, zero2, inf1, inf2, is_special, accept;
    logic [31:0] special_res;

    // Subnormal operands are flushed: they classify the same as zero.
    assign sign_in    = rs1_i[31] ^ rs2_i[31];
    assign zero1      = cls1[CLS_ZERO] | cls1[CLS_SUB];
    assign zero2      = cls2[CLS_ZERO] | cls2[CLS_SUB];
    assign inf1       = cls1[CLS_INF];
    assign inf2       = cls2[CLS_INF];
    assign is_special = !(cls1[CLS_NORM] && cls2[CLS_NORM]);
    assign accept     = fdivStart_i && (state == IDLE || state == DONE);

    always_comb begin
        special_res = {sign_in, 31'd0};
        if (cls1[CLS_QNAN])                       special_res = rs1_i;
        else if (cls2[CLS_QNAN])                  special_res = rs2_i;
        else if (cls1[CLS_SNAN])                  special_res = rs1_i;
        else if (cls2[CLS_SNAN])                  special_res = rs2_i;
        else if ((zero1 && zero2) || (inf1 && inf2))
                                                  special_res = {sign_in, CANON_QNAN[30:0]};
        else if (inf1 || zero2)                   special_res = {sign_in, 8'hFF, 23'd0};
    end

    logic        ge;
    logic [24:0] rem_next;

    assign ge       = rem >= {1'b0, dvs};
    assign rem_next = ge ? ((rem - {1'b0, dvs}) << 1) : (rem << 1);

    logic               lead;
    logic [22:0]        mant, sub_frac;
    logic signed [9:0]  exp_diff, exp_n;
    logic [4:0]         sub_sh;
    logic [31:0]        packed_res;

    // Quotient lies in (0.5, 2): the leading one sits in the top or next bit.
    assign lead     = quo[ITER-1];
    assign mant     = lead ? quo[ITER-2 -: 23] : quo[ITER-3 -: 23];
    assign exp_diff = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r});
    assign exp_n    = lead ? exp_diff : exp_diff - 10'sd1;
    assign sub_sh   = EXP_MIN[4:0] - exp_n[4:0];
    assign sub_frac = 23'({1'b1, mant} >> sub_sh);

    always_comb begin
        if (exp_n > EXP_MAX)           packed_res = {sign_r, 8'hFF, 23'd0};
        else if (exp_n >= EXP_MIN)     packed_res = {sign_r, exp_n[7:0] + BIAS, mant};
        else if (exp_n >= EXP_SUB_MIN) packed_res = {sign_r, 8'd0, sub_frac};
        else                           packed_res = {sign_r, 31'd0};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        fdivBusy_o = 1'b0;
        fdivDone_o = 1'b0;
        case (state)
            IDLE: begin
                if (fdivStart_i) state_next = is_special ? DONE : DIVIDE;
            end
            DIVIDE: begin
                fdivBusy_o = 1'b1;
                if (cnt == CNT_LAST) state_next = NORM;
            end
            NORM: begin
                fdivBusy_o = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                fdivDone_o = 1'b1;
                if (fdivStart_i) state_next = is_special ? DONE : DIVIDE;
                else             state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sign_r <= 1'b0;
            ea_r   <= '0;
            eb_r   <= '0;
            rem    <= '0;
            dvs    <= '0;
            quo    <= '0;
            cnt    <= '0;
            out_r  <= '0;
        end else if (accept) begin
            sign_r <= sign_in;
            ea_r   <= rs1_i[30:23];
            eb_r   <= rs2_i[30:23];
            rem    <= {2'b01, rs1_i[22:0]};
            dvs    <= {1'b1, rs2_i[22:0]};
            quo    <= '0;
            cnt    <= '0;
            if (is_special) out_r <= special_res;
        end else if (state == DIVIDE) begin
            rem <= rem_next;
            quo <= {quo[ITER-2:0], ge};
            cnt <= cnt + 1'b1;
        end else if (state == NORM) begin
            out_r <= packed_res;
        end
    end

    assign fdivOut_o = out_r;

endmodule
`default_nettype wire
